// File: rtl/fetch_controller.sv
// fetch_controller: owns the PC, issues one instruction-memory fetch at a time,
// presents the fetched word to decode and redirects on taken branches.
// Optional build macro FETCH_PERF_COUNT_EN adds fetch/redirect/drop counters.
`timescale 1ns/1ps
module fetch_controller #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              enable,
    output logic              imemReqValid,
    output logic [ADDR_W-1:0] imemReqAddr,
    input  logic              imemReqReady,
    input  logic              imemRspValid,
    input  logic [31:0]       imemRspData,
    output logic              instrValid,
    output logic [31:0]       instrData,
    output logic [ADDR_W-1:0] instrPC,
    input  logic              instrReady,
    input  logic              branchValid,
    input  logic              branchFlag,
    input  logic              zeroFlag,
    input  logic              unconditionalBranchFlag,
    input  logic [ADDR_W-1:0] branchPC,
    input  logic [31:0]       branchOffset,
    output logic [ADDR_W-1:0] readAddress
`ifdef FETCH_PERF_COUNT_EN
    ,
    output logic [31:0]       fetchCount,
    output logic [31:0]       redirectCount,
    output logic [31:0]       dropCount
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              drop_q, drop_d;
    logic              req_valid_q, req_valid_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       instr_data_q, instr_data_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;

    logic              taken;
    logic [ADDR_W-1:0] off_sh;
    logic [ADDR_W-1:0] target;

    // Branch resolution: sign-extended word offset scaled to bytes, wrapping add
    always_comb begin
        taken  = branchValid & ((branchFlag & zeroFlag) | unconditionalBranchFlag);
        off_sh = ADDR_W'({{ADDR_W{branchOffset[31]}}, branchOffset, 2'b00});
        target = branchPC + off_sh;
    end

    // Next-state, PC and instruction-latch logic; a redirect always wins over PC+4
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_d       = drop_q;
        instr_data_d = instr_data_q;
        instr_pc_d   = instr_pc_q;
        case (state_q)
            IDLE: begin
                if (taken) begin
                    pc_d = target;
                end else if (enable) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (taken) begin
                    pc_d = target;
                end
                if (imemReqReady) begin
                    state_d = WAIT;
                    // old address already accepted: its response must be thrown away
                    if (taken) begin
                        drop_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (taken) begin
                    pc_d = target;
                    if (imemRspValid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                    end
                end else if (imemRspValid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        instr_data_d = imemRspData;
                        instr_pc_d   = pc_q;
                        pc_d         = pc_q + ADDR_W'(32'd4);
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (taken) begin
                    pc_d    = target;
                    state_d = REQ;
                end else if (instrReady) begin
                    state_d = enable ? REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_valid_d   = (state_d == REQ);
        instr_valid_d = (state_d == HOLD);
    end

    // Controller state and registered outputs
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_q       <= IDLE;
            pc_q          <= RESET_PC;
            drop_q        <= 1'b0;
            req_valid_q   <= 1'b0;
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            instr_pc_q    <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            drop_q        <= drop_d;
            req_valid_q   <= req_valid_d;
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            instr_pc_q    <= instr_pc_d;
        end
    end

    assign imemReqValid = req_valid_q;
    assign imemReqAddr  = pc_q;
    assign readAddress  = pc_q;
    assign instrValid   = instr_valid_q;
    assign instrData    = instr_data_q;
    assign instrPC      = instr_pc_q;

`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] redir_cnt_q, redir_cnt_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;

    // Event counters: decode handshakes, taken branches, discarded responses
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + ((state_q == HOLD && instrReady) ? 32'd1 : 32'd0);
        redir_cnt_d = redir_cnt_q + (taken ? 32'd1 : 32'd0);
        drop_cnt_d  = drop_cnt_q +
                      ((state_q == WAIT && imemRspValid && (taken || drop_q)) ? 32'd1 : 32'd0);
    end

    // Counter registers
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            fetch_cnt_q <= '0;
            redir_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            redir_cnt_q <= redir_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign fetchCount    = fetch_cnt_q;
    assign redirectCount = redir_cnt_q;
    assign dropCount     = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: a program-order model predicts each
// delivered (PC, word) pair; a monitor pops and compares on every decode handshake.
`timescale 1ns/1ps
module tb_fetch_controller;

    localparam logic [31:0] RPC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        resetN = 1'b1;
    logic        enable = 1'b0;
    logic        imemReqValid;
    logic [31:0] imemReqAddr;
    logic        imemReqReady = 1'b0;
    logic        imemRspValid = 1'b0;
    logic [31:0] imemRspData = '0;
    logic        instrValid;
    logic [31:0] instrData;
    logic [31:0] instrPC;
    logic        instrReady = 1'b0;
    logic        branchValid = 1'b0;
    logic        branchFlag = 1'b0;
    logic        zeroFlag = 1'b0;
    logic        unconditionalBranchFlag = 1'b0;
    logic [31:0] branchPC = '0;
    logic [31:0] branchOffset = '0;
    logic [31:0] readAddress;
`ifdef FETCH_PERF_COUNT_EN
    logic [31:0] fetchCount, redirectCount, dropCount;
`endif

    fetch_controller #(.ADDR_W(32), .RESET_PC(RPC)) dut (
        .clock(clock), .resetN(resetN), .enable(enable),
        .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr), .imemReqReady(imemReqReady),
        .imemRspValid(imemRspValid), .imemRspData(imemRspData),
        .instrValid(instrValid), .instrData(instrData), .instrPC(instrPC), .instrReady(instrReady),
        .branchValid(branchValid), .branchFlag(branchFlag), .zeroFlag(zeroFlag),
        .unconditionalBranchFlag(unconditionalBranchFlag),
        .branchPC(branchPC), .branchOffset(branchOffset),
        .readAddress(readAddress)
`ifdef FETCH_PERF_COUNT_EN
        , .fetchCount(fetchCount), .redirectCount(redirectCount), .dropCount(dropCount)
`endif
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t exp_q[$];

    logic [31:0] next_pc = RPC;
    int          hs_count = 0;
    bit          mem_auto = 1'b0;
    bit          mem_rand = 1'b0;
    bit          late_rsp_req = 1'b0;
    bit          late_rsp_done = 1'b0;

    // Instruction memory contents: an address-dependent word
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a3c_96e1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 40; i++) begin
            if (instrValid) return;
            step();
        end
        tests++;
        fails++;
        $display("FAIL wait_valid: instrValid not seen within 40 cycles, required 1");
    endtask

    task automatic wait_req();
        for (int i = 0; i < 40; i++) begin
            if (imemReqValid) return;
            step();
        end
        tests++;
        fails++;
        $display("FAIL wait_req: imemReqValid not seen within 40 cycles, required 1");
    endtask

    task automatic drive_br(input bit v, input bit bf, input bit zf, input bit uf,
                            input logic [31:0] pc, input logic [31:0] off);
        branchValid             = v;
        branchFlag              = bf;
        zeroFlag                = zf;
        unconditionalBranchFlag = uf;
        branchPC                = pc;
        branchOffset            = off;
    endtask

    // Program-order model: each handshake consumes the next expected PC,
    // then a taken branch retargets the stream.
    initial forever begin
        @(posedge clock or negedge resetN);
        if (!resetN) begin
            next_pc = RPC;
            exp_q.delete();
        end else begin
            if (instrValid && instrReady) begin
                exp_q.push_back('{pc: next_pc, data: mem_word(next_pc)});
                next_pc = next_pc + 32'd4;
                hs_count++;
            end
            if (branchValid && ((branchFlag && zeroFlag) || unconditionalBranchFlag))
                next_pc = branchPC + branchOffset * 32'd4;
        end
    end

    // Monitor: capture each decode handshake and compare against the scoreboard
    logic [31:0] mon_pc, mon_data;
    exp_t        mon_e;
    initial forever begin
        @(negedge clock);
        if (resetN && instrValid && instrReady) begin
            mon_pc   = instrPC;
            mon_data = instrData;
            @(posedge clock);
            #1;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: delivered pc %h with nothing expected", mon_pc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_pc", mon_pc, mon_e.pc);
                chk("sb_data", mon_data, mon_e.data);
            end
        end
    end

    // Memory responder: one response per accepted request, latency 1 or random 1..3
    logic [31:0] r_addr;
    int          r_lat;
    initial forever begin
        @(posedge clock);
        if (mem_auto && resetN && imemReqValid && imemReqReady) begin
            r_addr = imemReqAddr;
            r_lat  = mem_rand ? int'($urandom_range(1, 3)) : 1;
            for (int k = 1; k < r_lat; k++) begin
                @(posedge clock);
                chk("one_outstanding", 32'(imemReqValid && imemReqReady), 32'd0);
            end
            #1;
            imemRspValid = 1'b1;
            imemRspData  = mem_word(r_addr);
            @(posedge clock);
            #1;
            imemRspValid = 1'b0;
            imemRspData  = $urandom;
        end else if (late_rsp_req && !late_rsp_done) begin
            #1;
            imemRspValid = 1'b1;
            imemRspData  = 32'hdead_beef;
            @(posedge clock);
            #1;
            imemRspValid  = 1'b0;
            late_rsp_done = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    int hs_start;
    int roff;

    initial begin
        // Asynchronous reset values
        #1 resetN = 1'b0;
        #1;
        chk("rst_req_valid", 32'(imemReqValid), 32'd0);
        chk("rst_req_addr", imemReqAddr, RPC);
        chk("rst_read_addr", readAddress, RPC);
        chk("rst_instr_valid", 32'(instrValid), 32'd0);
        chk("rst_instr_data", instrData, 32'd0);
        chk("rst_instr_pc", instrPC, 32'd0);
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
        mem_auto     = 1'b1;
        instrReady   = 1'b1;
        imemReqReady = 1'b1;
        step();
        enable = 1'b1;

        // Zero-wait sequential fetch: instrValid every third cycle
        for (int c = 1; c <= 8; c++) begin
            step();
            chk("seq_valid", 32'(instrValid), 32'(c % 3 == 0));
            if (c % 3 == 0) chk("seq_pc", instrPC, RPC + 32'(4 * (c / 3 - 1)));
            if (c == 8) instrReady = 1'b0;
        end

        // Decode backpressure holds the third instruction
        for (int c = 9; c <= 13; c++) begin
            step();
            chk("bp_valid", 32'(instrValid), 32'd1);
            chk("bp_data", instrData, mem_word(RPC + 32'd8));
            chk("bp_read_addr", readAddress, RPC + 32'd12);
            chk("bp_no_req", 32'(imemReqValid), 32'd0);
        end
        instrReady = 1'b1;

        // Taken conditional branch while waiting: in-flight word discarded
        wait_req();
        step();
        drive_br(1'b1, 1'b1, 1'b1, 1'b0, 32'h0000_0200, 32'hffff_fffe);
        step();
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("wait_br_req_valid", 32'(imemReqValid), 32'd1);
        chk("wait_br_req_addr", imemReqAddr, 32'h0000_01f8);
        chk("wait_br_read_addr", readAddress, 32'h0000_01f8);
        chk("wait_br_no_instr", 32'(instrValid), 32'd0);

        // Untaken branch in REQ with memory stalled
        imemReqReady = 1'b0;
        drive_br(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0700, 32'd5);
        step();
        chk("untaken_read_addr", readAddress, 32'h0000_01f8);
        chk("untaken_req_addr", imemReqAddr, 32'h0000_01f8);
        chk("untaken_req_valid", 32'(imemReqValid), 32'd1);

        // Unconditional branch with wrapping target, REQ not yet accepted
        drive_br(1'b1, 1'b0, 1'b0, 1'b1, 32'hffff_fffc, 32'd2);
        step();
        chk("wrap_req_addr", imemReqAddr, 32'h0000_0004);
        chk("wrap_read_addr", readAddress, 32'h0000_0004);
        chk("wrap_req_valid", 32'(imemReqValid), 32'd1);

        // Redirect coincident with acceptance: old response must be dropped
        imemReqReady = 1'b1;
        drive_br(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0300, 32'd4);
        step();
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("race_req_valid", 32'(imemReqValid), 32'd0);
        chk("race_read_addr", readAddress, 32'h0000_0310);
        step();
        chk("race_req_valid2", 32'(imemReqValid), 32'd1);
        chk("race_req_addr", imemReqAddr, 32'h0000_0310);
        chk("race_no_instr", 32'(instrValid), 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("cnt_fetch_a", fetchCount, 32'd3);
        chk("cnt_redirect_a", redirectCount, 32'd3);
        chk("cnt_drop_a", dropCount, 32'd2);
`endif

        // Redirect coincident with decode handshake: delivered, then target fetched
        wait_valid();
        drive_br(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0400, 32'hffff_ffff);
        step();
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("hold_br_req_valid", 32'(imemReqValid), 32'd1);
        chk("hold_br_req_addr", imemReqAddr, 32'h0000_03fc);
        chk("hold_br_no_instr", 32'(instrValid), 32'd0);

        // Reset pulsed while waiting for a response
        mem_auto = 1'b0;
        step();
        #3 resetN = 1'b0;
        enable = 1'b0;
        #1;
        chk("mid_rst_req_valid", 32'(imemReqValid), 32'd0);
        chk("mid_rst_req_addr", imemReqAddr, RPC);
        chk("mid_rst_read_addr", readAddress, RPC);
        chk("mid_rst_instr_valid", 32'(instrValid), 32'd0);
        chk("mid_rst_instr_data", instrData, 32'd0);
        chk("mid_rst_instr_pc", instrPC, 32'd0);
`ifdef FETCH_PERF_COUNT_EN
        chk("mid_rst_fetch_cnt", fetchCount, 32'd0);
        chk("mid_rst_redir_cnt", redirectCount, 32'd0);
        chk("mid_rst_drop_cnt", dropCount, 32'd0);
`endif
        @(posedge clock);
        #1 resetN = 1'b1;

        // Late response after release is ignored
        late_rsp_req = 1'b1;
        for (int i = 0; i < 10 && !late_rsp_done; i++) step();
        chk("late_rsp_sent", 32'(late_rsp_done), 32'd1);
        late_rsp_req = 1'b0;
        step();
        chk("late_rsp_no_instr", 32'(instrValid), 32'd0);
        chk("late_rsp_no_req", 32'(imemReqValid), 32'd0);
        chk("late_rsp_read_addr", readAddress, RPC);

        // Redirect in IDLE, then three fetches from the target
        mem_auto = 1'b1;
        drive_br(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0500, 32'd3);
        step();
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        chk("idle_br_read_addr", readAddress, 32'h0000_050c);
        chk("idle_br_no_req", 32'(imemReqValid), 32'd0);
        enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid();
            if (k == 2) enable = 1'b0;
            step();
        end
        chk("post3_no_req", 32'(imemReqValid), 32'd0);
        chk("post3_read_addr", readAddress, 32'h0000_0518);
`ifdef FETCH_PERF_COUNT_EN
        chk("cnt_fetch", fetchCount, 32'd3);
        chk("cnt_redirect", redirectCount, 32'd1);
        chk("cnt_drop", dropCount, 32'd0);
`endif

        // Randomized traffic against the program-order model
        mem_rand = 1'b1;
        hs_start = hs_count;
        for (int i = 0; i < 1500; i++) begin
            enable       = ($urandom % 8) != 0;
            imemReqReady = ($urandom % 4) != 0;
            instrReady   = ($urandom % 3) != 0;
            roff         = int'($urandom_range(0, 64)) - 32;
            drive_br(($urandom % 10) == 0, 1'($urandom), 1'($urandom), ($urandom % 3) == 0,
                     32'($urandom_range(0, 1023)) * 32'd4, 32'(roff));
            step();
        end
        drive_br(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        enable       = 1'b0;
        instrReady   = 1'b1;
        imemReqReady = 1'b1;
        repeat (20) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        tests++;
        if (hs_count - hs_start < 50) begin
            fails++;
            $display("FAIL rand_progress: %0d deliveries, required at least 50", hs_count - hs_start);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
